// File: rtl/acc_pkg.sv
// Shared types for the accelerator memory interface used by the FPU subsystem.
package acc_pkg;

    typedef enum logic {
        READ  = 1'b0,
        WRITE = 1'b1
    } mem_req_type_e;

endpackage

// File: rtl/fpu_ss_pipe_controller.sv
// Pipelined FPU subsystem controller: in-order issue with multiple FPU/memory ops in flight,
// a 32-entry FP register scoreboard, and arbitration of the single FP register write port.
module fpu_ss_pipe_controller #(
    parameter int unsigned MAX_FPU_INFLIGHT = 4,
    parameter int unsigned MAX_MEM_INFLIGHT = 2
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic                      instr_valid_i,
    output logic                      instr_ready_o,
    input  logic                      use_fpu_i,
    input  logic                      is_load_i,
    input  logic                      is_store_i,
    input  logic                      csr_instr_i,
    input  logic                      rd_is_fp_i,
    input  logic [4:0]                rd_i,
    input  logic [2:0][4:0]           rs_i,
    input  logic [2:0]                rs_used_i,
    output logic                      fpu_in_valid_o,
    input  logic                      fpu_in_ready_i,
    input  logic                      fpu_out_valid_i,
    output logic                      fpu_out_ready_o,
    output logic                      fpr_we_o,
    output logic [4:0]                fpr_waddr_o,
    output logic                      fpr_wsel_o,
    output logic                      c_p_valid_o,
    input  logic                      c_p_ready_i,
    output logic                      cmem_q_valid_o,
    input  logic                      cmem_q_ready_i,
    output acc_pkg::mem_req_type_e    cmem_q_req_type_o,
    output logic                      cmem_q_mode_o,
    output logic                      cmem_q_spec_o,
    output logic                      cmem_q_endoftransaction_o,
    input  logic                      cmem_p_valid_i,
    output logic                      cmem_p_ready_o,
    output logic                      busy_o
);

    localparam int unsigned FCW = $clog2(MAX_FPU_INFLIGHT + 1);
    localparam int unsigned MCW = $clog2(MAX_MEM_INFLIGHT + 1);
    localparam logic [FCW-1:0] FPU_MAX = FCW'(MAX_FPU_INFLIGHT);
    localparam logic [MCW-1:0] MEM_MAX = MCW'(MAX_MEM_INFLIGHT);

    typedef struct packed {
        logic       wr;   // FPU: writes an FP rd; mem: is a load
        logic [4:0] rd;
    } meta_t;

    meta_t [MAX_FPU_INFLIGHT-1:0] fpu_fifo_q, fpu_fifo_d;
    meta_t [MAX_MEM_INFLIGHT-1:0] mem_fifo_q, mem_fifo_d;
    logic  [FCW-1:0]              fpu_cnt_q, fpu_cnt_d, fpu_wr_idx;
    logic  [MCW-1:0]              mem_cnt_q, mem_cnt_d, mem_wr_idx;
    logic  [31:0]                 sb_q, sb_d, sb_set, sb_clr;

    logic hazard, fpu_busy, mem_busy, fpu_head_int, fpu_res, mem_resp, load_wb;
    logic fpu_ret, fpu_wb, csr_valid, fpu_issue, mem_issue, csr_issue;

    // NOTE: every variable assigned in an always_comb gets a default first, so no path infers a latch.
    always_comb begin
        hazard = rd_is_fp_i & sb_q[rd_i];
        for (int k = 0; k < 3; k++) begin
            if (rs_used_i[k] && sb_q[rs_i[k]]) hazard = 1'b1;
        end
    end

    // Responses arriving with nothing outstanding are ignored entirely.
    assign fpu_busy     = (fpu_cnt_q != '0);
    assign mem_busy     = (mem_cnt_q != '0);
    assign fpu_head_int = fpu_busy & ~fpu_fifo_q[0].wr;
    assign fpu_res      = fpu_out_valid_i & fpu_busy;
    assign mem_resp     = cmem_p_valid_i & mem_busy;
    assign load_wb      = mem_resp & mem_fifo_q[0].wr;

    assign fpu_out_ready_o = fpu_head_int ? c_p_ready_i : ~load_wb;
    assign fpu_ret         = fpu_res & fpu_out_ready_o;
    assign fpu_wb          = fpu_ret & fpu_fifo_q[0].wr;

    assign fpr_we_o    = load_wb | fpu_wb;
    assign fpr_wsel_o  = load_wb;
    assign fpr_waddr_o = load_wb ? mem_fifo_q[0].rd : fpu_fifo_q[0].rd;

    assign fpu_in_valid_o = instr_valid_i & use_fpu_i & ~hazard & (fpu_cnt_q < FPU_MAX);
    assign cmem_q_valid_o = instr_valid_i & (is_load_i | is_store_i) & ~hazard & (mem_cnt_q < MEM_MAX);
    assign csr_valid      = instr_valid_i & csr_instr_i & ~fpu_busy & ~mem_busy;
    assign c_p_valid_o    = (fpu_res & fpu_head_int) | csr_valid;

    assign fpu_issue     = fpu_in_valid_o & fpu_in_ready_i;
    assign mem_issue     = cmem_q_valid_o & cmem_q_ready_i;
    assign csr_issue     = csr_valid & c_p_ready_i;
    assign instr_ready_o = fpu_issue | mem_issue | csr_issue;

    assign cmem_q_req_type_o         = is_load_i ? acc_pkg::READ : acc_pkg::WRITE;
    assign cmem_q_mode_o             = 1'b0;
    assign cmem_q_spec_o             = 1'b0;
    assign cmem_q_endoftransaction_o = cmem_q_valid_o;
    assign cmem_p_ready_o            = 1'b1;
    assign busy_o                    = fpu_busy | mem_busy | (|sb_q);

    // Shift-down FIFOs: head always at index 0, a push lands just past the surviving entries.
    always_comb begin
        fpu_fifo_d = fpu_fifo_q;
        mem_fifo_d = mem_fifo_q;
        if (fpu_ret) begin
            for (int i = 0; i < int'(MAX_FPU_INFLIGHT) - 1; i++) fpu_fifo_d[i] = fpu_fifo_q[i+1];
            fpu_fifo_d[MAX_FPU_INFLIGHT-1] = '0;
        end
        if (mem_resp) begin
            for (int i = 0; i < int'(MAX_MEM_INFLIGHT) - 1; i++) mem_fifo_d[i] = mem_fifo_q[i+1];
            mem_fifo_d[MAX_MEM_INFLIGHT-1] = '0;
        end
        fpu_wr_idx = fpu_cnt_q - FCW'(fpu_ret);
        mem_wr_idx = mem_cnt_q - MCW'(mem_resp);
        for (int i = 0; i < int'(MAX_FPU_INFLIGHT); i++) begin
            if (fpu_issue && fpu_wr_idx == FCW'(i)) fpu_fifo_d[i] = '{wr: rd_is_fp_i, rd: rd_i};
        end
        for (int i = 0; i < int'(MAX_MEM_INFLIGHT); i++) begin
            if (mem_issue && mem_wr_idx == MCW'(i)) mem_fifo_d[i] = '{wr: is_load_i, rd: rd_i};
        end
        fpu_cnt_d = fpu_cnt_q + FCW'(fpu_issue) - FCW'(fpu_ret);
        mem_cnt_d = mem_cnt_q + MCW'(mem_issue) - MCW'(mem_resp);
    end

    always_comb begin
        sb_set = '0;
        sb_clr = '0;
        if (fpu_issue && rd_is_fp_i) sb_set[rd_i] = 1'b1;
        if (mem_issue && is_load_i)  sb_set[rd_i] = 1'b1;
        if (load_wb)                 sb_clr[mem_fifo_q[0].rd] = 1'b1;
        if (fpu_wb)                  sb_clr[fpu_fifo_q[0].rd] = 1'b1;
        sb_d = (sb_q & ~sb_clr) | sb_set;
    end

    // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
    // NOTE: the metadata FIFOs are reset too; a flush must leave no stale rd behind a zero count.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            fpu_fifo_q <= '0;
            mem_fifo_q <= '0;
            fpu_cnt_q  <= '0;
            mem_cnt_q  <= '0;
            sb_q       <= '0;
        end else begin
            fpu_fifo_q <= fpu_fifo_d;
            mem_fifo_q <= mem_fifo_d;
            fpu_cnt_q  <= fpu_cnt_d;
            mem_cnt_q  <= mem_cnt_d;
            sb_q       <= sb_d;
        end
    end

endmodule
